// File: rtl/ps2_keyboard.sv
// ---------------------------------------------------------------------------
// ps2_keyboard
//   Keyboard input terminal for the Apple-1 style system. Receives PS/2
//   set-2 scancodes, tracks make/break/extended prefixes and the shift keys,
//   translates key presses to upper-case 7-bit ASCII and queues the result in
//   a small FIFO that the CPU reads as KBD / KBDCR.
//
// Ports
//   clk       in   1  system clock (14 MHz)
//   rst_n     in   1  asynchronous active-low reset
//   enable    in   1  CPU clock-enable strobe
//   ps2_clk   in   1  PS/2 clock from the keyboard (asynchronous)
//   ps2_data  in   1  PS/2 data from the keyboard (asynchronous)
//   address   in   1  0 = KBD data register, 1 = KBDCR status register
//   r_en      in   1  read strobe, active high
//   dout      out  8  read data (combinational)
//   kbd_err   out  1  one-cycle pulse per discarded frame
// ---------------------------------------------------------------------------
module ps2_keyboard #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 14000,
    parameter int FIFO_AW     = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       address,
    input  logic       r_en,
    output logic [7:0] dout,
    output logic       kbd_err
);

    localparam int FW    = $clog2(FILTER_LEN + 1);
    localparam int TW    = $clog2(TIMEOUT_CYC + 1);
    localparam int DEPTH = 2 ** FIFO_AW;

    // -----------------------------------------------------------------------
    // Input conditioning: 2-FF synchronisers, then a stability filter on the
    // clock line. The bus idles high, so everything resets to 1.
    // -----------------------------------------------------------------------
    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic [FW-1:0] filt_cnt;
    logic          clk_filt;
    logic          sample;      // one-cycle pulse on a falling filtered edge

    // NOTE: state is updated with non-blocking assignments so every flop sees
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // The filtered clock only follows the synced clock once the two have
    // disagreed for FILTER_LEN consecutive cycles; shorter glitches vanish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_cnt <= '0;
            clk_filt <= 1'b1;
            sample   <= 1'b0;
        end else begin
            sample <= 1'b0;
            if (clk_sync[1] == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                filt_cnt <= '0;
                clk_filt <= clk_sync[1];
                sample   <= clk_filt;   // old level 1 -> new level 0
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Frame receiver
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

    rx_state_t     rx_state, rx_next;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg;
    logic          parity_bit;
    logic [TW-1:0] to_cnt;
    logic          timeout;
    logic          code_valid;
    logic          frame_err;
    logic          code_stb;
    logic [7:0]    code;

    assign timeout = (rx_state != RX_IDLE) && !sample &&
                     (to_cnt == TW'(TIMEOUT_CYC - 1));

    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        rx_next    = rx_state;
        code_valid = 1'b0;
        frame_err  = 1'b0;
        if (timeout) begin
            rx_next   = RX_IDLE;
            frame_err = 1'b1;
        end else if (sample) begin
            case (rx_state)
                RX_IDLE: begin
                    if (data_sync[1]) frame_err = 1'b1;
                    else              rx_next   = RX_DATA;
                end
                RX_DATA: begin
                    if (bit_cnt == 3'd7) rx_next = RX_PARITY;
                end
                RX_PARITY: rx_next = RX_STOP;
                RX_STOP: begin
                    rx_next = RX_IDLE;
                    // Odd parity: data plus parity bit holds an odd number of ones.
                    if (data_sync[1] && (^{parity_bit, shift_reg})) code_valid = 1'b1;
                    else                                            frame_err  = 1'b1;
                end
                default: rx_next = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state <= RX_IDLE;
        else        rx_state <= rx_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            to_cnt     <= '0;
            code_stb   <= 1'b0;
            code       <= '0;
            kbd_err    <= 1'b0;
        end else begin
            if (rx_state == RX_IDLE || sample) to_cnt <= '0;
            else                               to_cnt <= to_cnt + 1'b1;

            if (sample) begin
                case (rx_state)
                    RX_IDLE: bit_cnt <= '0;
                    RX_DATA: begin
                        shift_reg <= {data_sync[1], shift_reg[7:1]};   // LSB first
                        bit_cnt   <= bit_cnt + 1'b1;
                    end
                    RX_PARITY: parity_bit <= data_sync[1];
                    default: ;
                endcase
            end

            code_stb <= code_valid;
            if (code_valid) code <= shift_reg;
            kbd_err  <= frame_err;
        end
    end

    // -----------------------------------------------------------------------
    // Scancode decoder
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {DEC_NORMAL, DEC_BREAK, DEC_EXT, DEC_EXT_BREAK} dec_state_t;

    // Returns {hit, ascii}; hit = 0 for codes with no character.
    function automatic logic [7:0] translate(input logic [7:0] sc, input logic shifted);
        logic       hit;
        logic [6:0] ch;
        hit = 1'b1;
        ch  = 7'h00;
        case (sc)
            8'h1C: ch = 7'h41;  8'h32: ch = 7'h42;  8'h21: ch = 7'h43;
            8'h23: ch = 7'h44;  8'h24: ch = 7'h45;  8'h2B: ch = 7'h46;
            8'h34: ch = 7'h47;  8'h33: ch = 7'h48;  8'h43: ch = 7'h49;
            8'h3B: ch = 7'h4A;  8'h42: ch = 7'h4B;  8'h4B: ch = 7'h4C;
            8'h3A: ch = 7'h4D;  8'h31: ch = 7'h4E;  8'h44: ch = 7'h4F;
            8'h4D: ch = 7'h50;  8'h15: ch = 7'h51;  8'h2D: ch = 7'h52;
            8'h1B: ch = 7'h53;  8'h2C: ch = 7'h54;  8'h3C: ch = 7'h55;
            8'h2A: ch = 7'h56;  8'h1D: ch = 7'h57;  8'h22: ch = 7'h58;
            8'h35: ch = 7'h59;  8'h1A: ch = 7'h5A;
            8'h45: ch = shifted ? 7'h29 : 7'h30;
            8'h16: ch = shifted ? 7'h21 : 7'h31;
            8'h1E: ch = shifted ? 7'h40 : 7'h32;
            8'h26: ch = shifted ? 7'h23 : 7'h33;
            8'h25: ch = shifted ? 7'h24 : 7'h34;
            8'h2E: ch = shifted ? 7'h25 : 7'h35;
            8'h36: ch = shifted ? 7'h5E : 7'h36;
            8'h3D: ch = shifted ? 7'h26 : 7'h37;
            8'h3E: ch = shifted ? 7'h2A : 7'h38;
            8'h46: ch = shifted ? 7'h28 : 7'h39;
            8'h29: ch = 7'h20;
            8'h5A: ch = 7'h0D;
            8'h66: ch = 7'h5F;
            8'h76: ch = 7'h1B;
            8'h41: ch = shifted ? 7'h3C : 7'h2C;
            8'h49: ch = shifted ? 7'h3E : 7'h2E;
            8'h4A: ch = shifted ? 7'h3F : 7'h2F;
            8'h4C: ch = shifted ? 7'h3A : 7'h3B;
            8'h4E: ch = shifted ? 7'h5F : 7'h2D;
            8'h55: ch = shifted ? 7'h2B : 7'h3D;
            default: hit = 1'b0;
        endcase
        return {hit, ch};
    endfunction

    dec_state_t dec_state, dec_next;
    logic       shift, shift_next;
    logic       push_next;
    logic [7:0] xlat;
    logic       push_valid;
    logic [6:0] push_char;
    logic       is_shift_key;
    logic       is_ignored;

    assign xlat         = translate(code, shift);
    assign is_shift_key = (code == 8'h12) || (code == 8'h59);
    // Keyboard acknowledge / self-test / echo / resend bytes never affect state.
    assign is_ignored   = (code == 8'hAA) || (code == 8'hFA) ||
                          (code == 8'hEE) || (code == 8'hFE);

    always_comb begin
        dec_next   = dec_state;
        shift_next = shift;
        push_next  = 1'b0;
        if (code_stb && !is_ignored) begin
            case (dec_state)
                DEC_NORMAL: begin
                    if      (code == 8'hF0) dec_next   = DEC_BREAK;
                    else if (code == 8'hE0) dec_next   = DEC_EXT;
                    else if (is_shift_key)  shift_next = 1'b1;
                    else                    push_next  = xlat[7];
                end
                DEC_BREAK: begin
                    if (is_shift_key) shift_next = 1'b0;
                    dec_next = DEC_NORMAL;
                end
                DEC_EXT:       dec_next = (code == 8'hF0) ? DEC_EXT_BREAK : DEC_NORMAL;
                DEC_EXT_BREAK: dec_next = DEC_NORMAL;
                default:       dec_next = DEC_NORMAL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_state  <= DEC_NORMAL;
            shift      <= 1'b0;
            push_valid <= 1'b0;
            push_char  <= '0;
        end else begin
            dec_state  <= dec_next;
            shift      <= shift_next;
            push_valid <= push_next;
            if (push_next) push_char <= xlat[6:0];
        end
    end

    // -----------------------------------------------------------------------
    // Character FIFO and CPU read port
    // -----------------------------------------------------------------------
    logic [6:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               empty, full;
    logic               rd_seen;
    logic               pop, push;

    assign empty = (count == '0);
    assign full  = count[FIFO_AW];
    // One pop per read transaction: rd_seen blocks held strobes.
    assign pop   = enable && r_en && !rd_seen && !address && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push  = push_valid && (!full || pop);

    // NOTE: the storage array has no reset; the pointers and count alone
    // decide which entries are valid, so clearing the data would be wasted.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_char;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_seen <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (enable && r_en)        rd_seen <= 1'b1;
            else if (!enable && !r_en) rd_seen <= 1'b0;
        end
    end

    // Read data is held at zero while reset is asserted.
    always_comb begin
        dout = 8'h00;
        if (rst_n) begin
            if (address)    dout = {~empty, 7'b0};
            else if (empty) dout = 8'h80;
            else            dout = {1'b1, mem[rd_ptr]};
        end
    end

endmodule

// File: tb/tb_ps2_keyboard.sv
// ---------------------------------------------------------------------------
// tb_ps2_keyboard
//   Drives PS/2 frames into ps2_keyboard, predicts the queued characters and
//   error pulses with a keystroke-level model, and checks CPU reads and
//   kbd_err pulses from a separate monitor process via scoreboard queues.
// ---------------------------------------------------------------------------
module tb_ps2_keyboard;

    localparam int FILTER_LEN  = 8;
    localparam int TIMEOUT_CYC = 14000;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       enable   = 1'b0;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic       address  = 1'b0;
    logic       r_en     = 1'b0;
    logic [7:0] dout;
    logic       kbd_err;

    ps2_keyboard #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .FIFO_AW    (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .address (address),
        .r_en    (r_en),
        .dout    (dout),
        .kbd_err (kbd_err)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Scoreboards
    logic [7:0] rd_exp_q[$];
    string      rd_name_q[$];
    bit         err_q[$];

    // Keystroke-level reference model
    byte unsigned plain_map[byte unsigned];
    byte unsigned shift_map[byte unsigned];
    byte unsigned mdl_fifo[$];
    bit           mdl_shift, mdl_brk, mdl_ext;

    byte unsigned letter_codes[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                       8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                       8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                       8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    byte unsigned digit_codes[10]  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                       8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    byte unsigned punct_codes[6]   = '{8'h41, 8'h49, 8'h4A, 8'h4C, 8'h4E, 8'h55};
    byte unsigned pool[24]         = '{8'h1C, 8'h32, 8'h21, 8'h1A, 8'h16, 8'h1E, 8'h45,
                                       8'h25, 8'h29, 8'h5A, 8'h66, 8'h76, 8'h41, 8'h4C,
                                       8'h4E, 8'h55, 8'h12, 8'h59, 8'hF0, 8'hF0, 8'hE0,
                                       8'hAA, 8'hFA, 8'h13};

    function automatic void build_maps();
        string digit_sym = ")!@#$%^&*(";
        string punct_lo  = ",./;-=";
        string punct_hi  = "<>?:_+";
        for (int i = 0; i < 26; i++) begin
            plain_map[letter_codes[i]] = 8'h41 + i;
            shift_map[letter_codes[i]] = 8'h41 + i;
        end
        for (int i = 0; i < 10; i++) begin
            plain_map[digit_codes[i]] = 8'h30 + i;
            shift_map[digit_codes[i]] = digit_sym[i];
        end
        for (int i = 0; i < 6; i++) begin
            plain_map[punct_codes[i]] = punct_lo[i];
            shift_map[punct_codes[i]] = punct_hi[i];
        end
        plain_map[8'h29] = 8'h20; shift_map[8'h29] = 8'h20;
        plain_map[8'h5A] = 8'h0D; shift_map[8'h5A] = 8'h0D;
        plain_map[8'h66] = 8'h5F; shift_map[8'h66] = 8'h5F;
        plain_map[8'h76] = 8'h1B; shift_map[8'h76] = 8'h1B;
    endfunction

    function automatic void model_reset();
        mdl_fifo.delete();
        mdl_shift = 1'b0;
        mdl_brk   = 1'b0;
        mdl_ext   = 1'b0;
    endfunction

    // A completed scancode as seen by the key tracker.
    function automatic void model_key(input byte unsigned c);
        bit shift_key = (c == 8'h12) || (c == 8'h59);
        if (c inside {8'hAA, 8'hFA, 8'hEE, 8'hFE}) return;
        if (mdl_brk) begin
            if (!mdl_ext && shift_key) mdl_shift = 1'b0;
            mdl_brk = 1'b0;
            mdl_ext = 1'b0;
        end else if (mdl_ext) begin
            if (c == 8'hF0) mdl_brk = 1'b1;
            else            mdl_ext = 1'b0;
        end else if (c == 8'hF0) begin
            mdl_brk = 1'b1;
        end else if (c == 8'hE0) begin
            mdl_ext = 1'b1;
        end else if (shift_key) begin
            mdl_shift = 1'b1;
        end else if (plain_map.exists(c)) begin
            if (mdl_fifo.size() < 4)
                mdl_fifo.push_back(mdl_shift ? shift_map[c] : plain_map[c]);
        end
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One PS/2 bit: data set while the clock is high, then a 30-cycle low phase.
    task automatic ps2_bit(input bit b, input bit glitch);
        ps2_data = b;
        wait_cycles(15);
        ps2_clk = 1'b0;
        wait_cycles(30);
        ps2_clk = 1'b1;
        if (glitch) begin
            wait_cycles(5);
            ps2_clk = 1'b0;
            wait_cycles(3);
            ps2_clk = 1'b1;
            wait_cycles(7);
        end else begin
            wait_cycles(15);
        end
    endtask

    task automatic send_frame(input byte unsigned c, input bit bad_par, input bit bad_stop,
                              input int glitch_bit);
        bit [10:0] f;
        f[0]   = 1'b0;
        f[8:1] = c;
        f[9]   = ~(^c) ^ bad_par;
        f[10]  = ~bad_stop;
        if (bad_par || bad_stop) err_q.push_back(1'b1);
        for (int i = 0; i < 11; i++) ps2_bit(f[i], i == glitch_bit);
        ps2_data = 1'b1;
        wait_cycles(40);
        if (!bad_par && !bad_stop) model_key(c);
    endtask

    task automatic partial_frame(input byte unsigned c, input int nbits);
        bit [8:0] f;
        f = {c, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(f[i], 1'b0);
        ps2_data = 1'b1;
    endtask

    task automatic kbd_read(input bit addr, input int hold, input string name);
        logic [7:0] exp;
        if (addr) begin
            exp = (mdl_fifo.size() != 0) ? 8'h80 : 8'h00;
        end else if (mdl_fifo.size() == 0) begin
            exp = 8'h80;
        end else begin
            exp = 8'h80 | mdl_fifo[0];
            mdl_fifo.delete(0);
        end
        rd_exp_q.push_back(exp);
        rd_name_q.push_back(name);
        address = addr;
        enable  = 1'b1;
        r_en    = 1'b1;
        wait_cycles(hold);
        enable  = 1'b0;
        r_en    = 1'b0;
        wait_cycles(2);
    endtask

    task automatic check_drained(input string name);
        check({name, "_err_drain"}, err_q.size(), 0);
        check({name, "_rd_drain"}, rd_exp_q.size(), 0);
    endtask

    // Monitor: compares on the first cycle of each read and on every kbd_err pulse.
    logic prev_rd = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (enable && r_en && !prev_rd) begin
                if (rd_exp_q.size() == 0) begin
                    check("rd_unexpected", rd_exp_q.size(), 1);
                end else begin
                    check(rd_name_q.pop_front(), dout, rd_exp_q.pop_front());
                end
            end
            if (kbd_err) begin
                check("kbd_err_expected", err_q.size() != 0, 1);
                if (err_q.size() != 0) void'(err_q.pop_front());
            end
        end
        prev_rd <= enable && r_en;
    end

    initial begin
        build_maps();
        model_reset();

        // Reset values
        wait_cycles(3);
        check("reset_dout", dout, 8'h00);
        check("reset_err", kbd_err, 1'b0);
        rst_n = 1'b1;
        wait_cycles(3);
        kbd_read(1'b1, 1, "init_kbdcr");
        kbd_read(1'b0, 1, "init_kbd_empty");

        // Single frame 1C
        send_frame(8'h1C, 0, 0, -1);
        kbd_read(1'b1, 1, "s1_kbdcr_full");
        kbd_read(1'b0, 1, "s1_kbd");
        kbd_read(1'b1, 1, "s1_kbdcr_after");
        check_drained("s1");

        // Shift make/break sequence
        foreach (pool[i]) if (i == 0) ; // keeps pool referenced before random phase
        send_frame(8'h12, 0, 0, -1);
        send_frame(8'h16, 0, 0, -1);
        send_frame(8'hF0, 0, 0, -1);
        send_frame(8'h16, 0, 0, -1);
        send_frame(8'hF0, 0, 0, -1);
        send_frame(8'h12, 0, 0, -1);
        send_frame(8'h16, 0, 0, -1);
        kbd_read(1'b0, 1, "s2_bang");
        kbd_read(1'b0, 1, "s2_one");
        check_drained("s2");

        // Bad parity and bad stop bit
        send_frame(8'h1C, 1, 0, -1);
        kbd_read(1'b1, 1, "s3_parity_kbdcr");
        send_frame(8'h1C, 0, 1, -1);
        kbd_read(1'b1, 1, "s3_stop_kbdcr");
        check_drained("s3");

        // Timeout mid-frame, then a clean frame
        err_q.push_back(1'b1);
        partial_frame(8'h5A, 4);
        wait_cycles(TIMEOUT_CYC + 100);
        check_drained("s4_timeout");
        send_frame(8'h5A, 0, 0, -1);
        kbd_read(1'b0, 1, "s4_cr");
        check_drained("s4");

        // FIFO overflow
        send_frame(8'h1C, 0, 0, -1);
        send_frame(8'h32, 0, 0, -1);
        send_frame(8'h21, 0, 0, -1);
        send_frame(8'h23, 0, 0, -1);
        send_frame(8'h24, 0, 0, -1);
        for (int i = 0; i < 5; i++) kbd_read(1'b0, 1, "s5_overflow_read");
        check_drained("s5");

        // Held strobe pops only once
        send_frame(8'h1C, 0, 0, -1);
        send_frame(8'h32, 0, 0, -1);
        kbd_read(1'b0, 3, "s6_held");
        kbd_read(1'b0, 1, "s6_next");
        kbd_read(1'b0, 1, "s6_empty");
        check_drained("s6");

        // Reset mid-frame
        send_frame(8'h1C, 0, 0, -1);
        partial_frame(8'h16, 5);
        address = 1'b0;
        rst_n   = 1'b0;
        model_reset();
        wait_cycles(2);
        check("s7_reset_dout", dout, 8'h00);
        check("s7_reset_err", kbd_err, 1'b0);
        rst_n = 1'b1;
        wait_cycles(3);
        kbd_read(1'b1, 1, "s7_kbdcr");
        send_frame(8'h1C, 0, 0, -1);
        kbd_read(1'b0, 1, "s7_after");
        check_drained("s7");

        // Glitches on ps2_clk, idle and mid-frame
        ps2_clk = 1'b0;
        wait_cycles(3);
        ps2_clk = 1'b1;
        wait_cycles(40);
        send_frame(8'h32, 0, 0, 3);
        kbd_read(1'b0, 1, "s8_glitch");
        check_drained("s8");

        // Randomized traffic
        for (int n = 0; n < 30; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0)      send_frame(pool[$urandom_range(0, 23)], 1, 0, -1);
            else if (r <= 2) kbd_read(1'b0, $urandom_range(1, 3), "rnd_kbd");
            else if (r == 3) kbd_read(1'b1, 1, "rnd_kbdcr");
            else             send_frame(pool[$urandom_range(0, 23)], 0, 0, -1);
        end
        while (mdl_fifo.size() != 0) kbd_read(1'b0, 1, "rnd_drain");
        kbd_read(1'b0, 1, "rnd_final_empty");
        wait_cycles(5);
        check_drained("rnd");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
